viterbi_step_ctrl: RTL and testbench



---
 rtl/viterbi_step_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_viterbi_step_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_step_ctrl.sv
// rtl/viterbi_step_ctrl.sv - Viterbi decoder step sequencer
//
// Accepts received hard-decision symbol pairs over a valid/ready handshake and
// turns every accepted pair into one trellis step for the bmc/acs array. It
// also owns the survivor-memory write pointer, raises a traceback request every
// TB_LEN steps (and once more at end of frame), and generates the path-metric
// init and normalization strobes.
//
// Optional feature macro: VITERBI_NORM_EN
//   defined   : a rising edge of the registered pm_ovf schedules one norm
//               strobe, issued together with the next acs_en.
//   undefined : norm is tied low and pm_ovf is ignored.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid        symbol pair valid
//   in_ready        controller can accept a pair (high only while running)
//   in_pair         received hard-decision pair
//   in_last         pair is the last of the frame
//   bmc_rx_pair     registered pair presented to the bmc array
//   acs_en          ACS update strobe, one per step
//   pm_init         load initial path metrics (one cycle per frame)
//   sm_wr_en        survivor column write strobe
//   sm_wr_addr      survivor column address of the current write
//   tb_start        traceback request pulse
//   tb_addr         column the traceback starts from, held until tb_done
//   tb_final        current request is the end-of-frame flush
//   tb_done         traceback unit finished, one-cycle pulse
//   pm_ovf          ACS reports a path-metric MSB set
//   norm            subtract-normalize strobe to the ACS
//   frame_done      one-cycle pulse, frame fully traced back

module viterbi_step_ctrl #(
    parameter int SM_DEPTH = 64,
    parameter int AW       = 6,
    parameter int TB_LEN   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_pair,
    input  logic          in_last,
    output logic [1:0]    bmc_rx_pair,
    output logic          acs_en,
    output logic          pm_init,
    output logic          sm_wr_en,
    output logic [AW-1:0] sm_wr_addr,
    output logic          tb_start,
    output logic [AW-1:0] tb_addr,
    output logic          tb_final,
    input  logic          tb_done,
    input  logic          pm_ovf,
    output logic          norm,
    output logic          frame_done
);

    localparam int CW = (TB_LEN > 1) ? $clog2(TB_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_TB_WAIT,
        S_FLUSH
    } state_t;

    state_t        state_q;

    logic          in_ready_q;
    logic [1:0]    bmc_rx_pair_q;
    logic          acs_en_q;
    logic          pm_init_q;
    logic          sm_wr_en_q;
    logic [AW-1:0] sm_wr_addr_q;
    logic          tb_start_q;
    logic [AW-1:0] tb_addr_q;
    logic          tb_final_q;
    logic          frame_done_q;

    // Next free survivor column and position inside the current TB_LEN block.
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [CW-1:0] step_cnt_q;
    logic [CW-1:0] step_cnt_d;

    // A traceback request is in flight at the traceback unit.
    logic          tb_busy_q;
    // Request that could not be issued because one was already in flight.
    logic [AW-1:0] pend_addr_q;
    logic          pend_final_q;

    logic          accept;
    logic          step_wrap;
    logic          req_due;
    logic          tb_busy_eff;

    always_comb begin
        accept      = in_valid & in_ready_q;
        step_wrap   = (step_cnt_q == CW'(TB_LEN - 1));
        req_due     = accept & (step_wrap | in_last);
        // A tb_done in the same cycle frees the unit before the new request
        // is considered, so a coincident completion never causes a stall.
        tb_busy_eff = tb_busy_q & ~tb_done;
        wr_ptr_d    = (wr_ptr_q == AW'(SM_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        step_cnt_d  = step_wrap ? '0 : step_cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b0;
            bmc_rx_pair_q <= '0;
            acs_en_q      <= 1'b0;
            pm_init_q     <= 1'b0;
            sm_wr_en_q    <= 1'b0;
            sm_wr_addr_q  <= '0;
            tb_start_q    <= 1'b0;
            tb_addr_q     <= '0;
            tb_final_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            wr_ptr_q      <= '0;
            step_cnt_q    <= '0;
            tb_busy_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_final_q  <= 1'b0;
        end else begin
            acs_en_q     <= 1'b0;
            sm_wr_en_q   <= 1'b0;
            pm_init_q    <= 1'b0;
            tb_start_q   <= 1'b0;
            frame_done_q <= 1'b0;

            // Completion clears the in-flight flag; a request issued below in
            // the same cycle sets it again (later assignment wins).
            if (tb_done) begin
                tb_busy_q <= 1'b0;
            end

            // Every accepted pair is one trellis step, presented next cycle.
            if (accept) begin
                bmc_rx_pair_q <= in_pair;
                acs_en_q      <= 1'b1;
                sm_wr_en_q    <= 1'b1;
                sm_wr_addr_q  <= wr_ptr_q;
                wr_ptr_q      <= wr_ptr_d;
                step_cnt_q    <= step_cnt_d;
            end

            case (state_q)
                S_IDLE: begin
                    // The waiting pair is left on the bus; it is taken in RUN.
                    if (in_valid) begin
                        pm_init_q <= 1'b1;
                        state_q   <= S_INIT;
                    end
                end

                S_INIT: begin
                    wr_ptr_q     <= '0;
                    step_cnt_q   <= '0;
                    sm_wr_addr_q <= '0;
                    tb_busy_q    <= 1'b0;
                    in_ready_q   <= 1'b1;
                    state_q      <= S_RUN;
                end

                S_RUN: begin
                    if (req_due) begin
                        if (!tb_busy_eff) begin
                            // tb_start lines up with the sm_wr_en of this column.
                            tb_start_q <= 1'b1;
                            tb_addr_q  <= wr_ptr_q;
                            tb_final_q <= in_last;
                            tb_busy_q  <= 1'b1;
                            if (in_last) begin
                                in_ready_q <= 1'b0;
                                state_q    <= S_FLUSH;
                            end
                        end else begin
                            // Column is still written; only the request waits.
                            pend_addr_q  <= wr_ptr_q;
                            pend_final_q <= in_last;
                            in_ready_q   <= 1'b0;
                            state_q      <= S_TB_WAIT;
                        end
                    end
                end

                S_TB_WAIT: begin
                    if (tb_done && tb_busy_q) begin
                        tb_start_q <= 1'b1;
                        tb_addr_q  <= pend_addr_q;
                        tb_final_q <= pend_final_q;
                        tb_busy_q  <= 1'b1;
                        if (pend_final_q) begin
                            state_q <= S_FLUSH;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= S_RUN;
                        end
                    end
                end

                S_FLUSH: begin
                    // Only the final request can be in flight here.
                    if (tb_done && tb_busy_q) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end

                default: begin
                    in_ready_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef VITERBI_NORM_EN
    logic pm_ovf_q;
    logic pm_ovf_prev_q;
    logic norm_pend_q;
    logic norm_q;

    // Only a low-to-high transition of the registered overflow flag arms a
    // normalization, so a flag held high for many cycles yields one strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            pm_ovf_q      <= 1'b0;
            pm_ovf_prev_q <= 1'b0;
            norm_pend_q   <= 1'b0;
            norm_q        <= 1'b0;
        end else begin
            pm_ovf_q      <= pm_ovf;
            pm_ovf_prev_q <= pm_ovf_q;
            norm_q        <= 1'b0;
            if (accept && norm_pend_q) begin
                norm_q      <= 1'b1;
                norm_pend_q <= 1'b0;
            end
            if (pm_ovf_q && !pm_ovf_prev_q) begin
                norm_pend_q <= 1'b1;
            end
        end
    end

    assign norm = norm_q;
`else
    logic unused_pm_ovf;
    assign unused_pm_ovf = pm_ovf;
    assign norm          = 1'b0;
`endif

    assign in_ready    = in_ready_q;
    assign bmc_rx_pair = bmc_rx_pair_q;
    assign acs_en      = acs_en_q;
    assign pm_init     = pm_init_q;
    assign sm_wr_en    = sm_wr_en_q;
    assign sm_wr_addr  = sm_wr_addr_q;
    assign tb_start    = tb_start_q;
    assign tb_addr     = tb_addr_q;
    assign tb_final    = tb_final_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_viterbi_step_ctrl.sv
// tb/tb_viterbi_step_ctrl.sv - scoreboard bench for viterbi_step_ctrl
module tb_viterbi_step_ctrl;

    localparam int SM_DEPTH = 64;
    localparam int AW       = 6;
    localparam int TB_LEN   = 32;

    localparam int M_RUN   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_FLUSH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_pair;
    logic          in_last;
    logic [1:0]    bmc_rx_pair;
    logic          acs_en;
    logic          pm_init;
    logic          sm_wr_en;
    logic [AW-1:0] sm_wr_addr;
    logic          tb_start;
    logic [AW-1:0] tb_addr;
    logic          tb_final;
    logic          tb_done;
    logic          pm_ovf;
    logic          norm;
    logic          frame_done;

    viterbi_step_ctrl #(.SM_DEPTH(SM_DEPTH), .AW(AW), .TB_LEN(TB_LEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pair(in_pair), .in_last(in_last), .bmc_rx_pair(bmc_rx_pair),
        .acs_en(acs_en), .pm_init(pm_init), .sm_wr_en(sm_wr_en),
        .sm_wr_addr(sm_wr_addr), .tb_start(tb_start), .tb_addr(tb_addr),
        .tb_final(tb_final), .tb_done(tb_done), .pm_ovf(pm_ovf), .norm(norm),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t wq[$];   // expected writes: cycle, pair, column
    ev_t tq[$];   // expected traceback requests: cycle, column, final
    ev_t iq[$];   // expected pm_init pulses
    ev_t fq[$];   // expected frame_done pulses

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int norm_cnt = 0;
    int frame_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        ev_t e;
        if (sm_wr_en === 1'b1 || acs_en === 1'b1) begin
            chk("write_expected", (wq.size() != 0), 1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                chk("write_cycle", cyc, e.cyc);
                chk("bmc_rx_pair", bmc_rx_pair, e.a);
                chk("sm_wr_addr", sm_wr_addr, e.b);
                chk("acs_en", acs_en, 1);
                chk("sm_wr_en", sm_wr_en, 1);
            end
        end
        if (tb_start === 1'b1) begin
            chk("tb_start_expected", (tq.size() != 0), 1);
            if (tq.size() != 0) begin
                e = tq.pop_front();
                chk("tb_start_cycle", cyc, e.cyc);
                chk("tb_addr", tb_addr, e.a);
                chk("tb_final", tb_final, e.b);
            end
        end
        if (pm_init === 1'b1) begin
            chk("pm_init_expected", (iq.size() != 0), 1);
            if (iq.size() != 0) begin
                e = iq.pop_front();
                chk("pm_init_cycle", cyc, e.cyc);
            end
        end
        if (frame_done === 1'b1) begin
            chk("frame_done_expected", (fq.size() != 0), 1);
            if (fq.size() != 0) begin
                e = fq.pop_front();
                chk("frame_done_cycle", cyc, e.cyc);
            end
        end
        if (norm === 1'b1) begin
            norm_cnt++;
            chk("norm_with_acs_en", acs_en, 1);
        end
    end

    // One frame: model of the sequencing rules plus a traceback-unit responder.
    // delay > 0 fixes the tb_done latency after each request, 0 randomizes it.
    task automatic run_frame(input int n_steps, input int gap_pct, input int delay,
                             input int abort_at, input int ovf_at);
        int mode = M_RUN;
        int n = 0;
        bit outst = 0;
        int timer = 0;
        int cur_addr = 0;
        bit cur_final = 0;
        int pend_addr = 0;
        bit pend_final = 0;
        int ovf_cnt = 0;
        bit ovf_started = 0;
        bit done = 0;
        bit aborting = 0;
        bit vld, tbd, last;
        logic [1:0] pair;
        int addr;
        int guard = 0;

        tb_done = 0;
        pm_ovf = 0;
        in_valid = 0;
        pair = (frame_idx == 0) ? 2'b10 : 2'($urandom);
        frame_idx++;
        repeat ($urandom_range(0, 2)) begin
            chk("in_ready_idle", in_ready, 0);
            tick();
        end
        chk("in_ready_idle", in_ready, 0);
        in_valid = 1;
        in_pair = pair;
        in_last = (n_steps == 1);
        iq.push_back('{cyc + 1, 0, 0});
        tick();
        chk("in_ready_init", in_ready, 0);
        tick();

        while (!done) begin
            guard++;
            if (guard > 4000) begin
                chk("frame_finished", done, 1);
                break;
            end
            tbd = 0;
            if (outst && timer == 0) tbd = 1;
            else if (!outst && mode == M_RUN && $urandom_range(0, 15) == 0) tbd = 1;
            chk("in_ready", in_ready, (mode == M_RUN));
            if (tbd && outst) begin
                chk("tb_addr_held", tb_addr, cur_addr);
                chk("tb_final_held", tb_final, cur_final);
            end
            vld = (mode == M_RUN) && (n < n_steps) && ($urandom_range(0, 99) >= gap_pct);
            last = (n == n_steps - 1);
            if (n == ovf_at && !ovf_started) begin
                ovf_cnt = 3;
                ovf_started = 1;
            end
            pm_ovf = (ovf_cnt > 0);
            if (ovf_cnt > 0) ovf_cnt--;
            in_valid = vld;
            in_pair = pair;
            in_last = last;
            tb_done = tbd;

            if (tbd && outst) begin
                outst = 0;
                if (mode == M_WAIT) begin
                    tq.push_back('{cyc + 1, pend_addr, pend_final});
                    outst = 1;
                    cur_addr = pend_addr;
                    cur_final = pend_final;
                    timer = (delay > 0) ? delay : $urandom_range(1, 8);
                    mode = pend_final ? M_FLUSH : M_RUN;
                end else if (mode == M_FLUSH) begin
                    fq.push_back('{cyc + 1, 0, 0});
                    done = 1;
                end
            end
            if (vld) begin
                addr = n % SM_DEPTH;
                n++;
                wq.push_back('{cyc + 1, pair, addr});
                if ((n % TB_LEN) == 0 || last) begin
                    if (!outst) begin
                        tq.push_back('{cyc + 1, addr, last});
                        outst = 1;
                        cur_addr = addr;
                        cur_final = last;
                        timer = (delay > 0) ? delay : $urandom_range(1, 8);
                        if (last) mode = M_FLUSH;
                    end else begin
                        pend_addr = addr;
                        pend_final = last;
                        mode = M_WAIT;
                    end
                end
                pair = 2'($urandom);
                if (n == abort_at) aborting = 1;
            end
            if (outst && timer > 0) timer--;
            tick();
            if (aborting) begin
                rst = 1;
                in_valid = 0;
                tb_done = 0;
                pm_ovf = 0;
                tick();
                tick();
                rst = 0;
                chk("abort_in_ready", in_ready, 0);
                chk("abort_sm_wr_en", sm_wr_en, 0);
                chk("abort_tb_start", tb_start, 0);
                chk("abort_tb_addr", tb_addr, 0);
                chk("abort_frame_done", frame_done, 0);
                done = 1;
            end
        end
        tb_done = 0;
        in_valid = 0;
        pm_ovf = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation stuck at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1;
        in_valid = 0;
        in_pair = 0;
        in_last = 0;
        tb_done = 0;
        pm_ovf = 0;
        tick();
        tick();
        chk("reset_in_ready", in_ready, 0);
        chk("reset_bmc_rx_pair", bmc_rx_pair, 0);
        chk("reset_acs_en", acs_en, 0);
        chk("reset_pm_init", pm_init, 0);
        chk("reset_sm_wr_en", sm_wr_en, 0);
        chk("reset_sm_wr_addr", sm_wr_addr, 0);
        chk("reset_tb_start", tb_start, 0);
        chk("reset_tb_addr", tb_addr, 0);
        chk("reset_tb_final", tb_final, 0);
        chk("reset_norm", norm, 0);
        chk("reset_frame_done", frame_done, 0);
        rst = 0;

        run_frame(70, 0, 40, -1, 10);   // stall at step 64, wrap to column 0, deferred final
        run_frame(70, 0, 32, -1, -1);   // tb_done coincides with step 64 acceptance
        run_frame(32, 0, 3, -1, -1);    // in_last on the 32nd pair: one final request
        run_frame(40, 0, 6, -1, -1);    // in_last on pair 40: final request at column 39
        run_frame(60, 20, 0, 45, -1);   // reset in the middle of a frame
        run_frame(1, 0, 0, -1, -1);     // single-pair frame
        for (int f = 0; f < 8; f++) begin
            run_frame($urandom_range(1, 130), $urandom_range(0, 50), 0, -1, -1);
        end

        repeat (4) tick();
        chk("writes_drained", wq.size(), 0);
        chk("tb_requests_drained", tq.size(), 0);
        chk("pm_init_drained", iq.size(), 0);
        chk("frame_done_drained", fq.size(), 0);
`ifdef VITERBI_NORM_EN
        chk("norm_count", norm_cnt, 1);
`else
        chk("norm_count", norm_cnt, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
